// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one master the shared bus and latching its target slave ID.
// Latency: request sampled at edge k is granted after edge k; one TURN cycle follows every release.
// Backpressure: owner holds the bus until txn_done, request drop or timeout; other requests wait in IDLE.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int SLAVE_ID_W     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS*SLAVE_ID_W-1:0] m_slave_id,
    input  logic                              txn_done,
    output logic [NUM_MASTERS-1:0]            m_grant,
    output logic                              bus_busy,
    output logic [SLAVE_ID_W-1:0]             slave_sel,
    output logic                              slave_sel_valid,
    output logic                              timeout
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [CNT_W-1:0]  count;

    logic              any_req;
    logic              hi_found;
    logic              lo_found;
    logic [PTR_W-1:0]  hi_idx;
    logic [PTR_W-1:0]  lo_idx;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  ptr_after_win;
    logic [SLAVE_ID_W-1:0] win_slave_id;
    logic              owner_req;
    logic              at_limit;
    logic              release_now;

    // Round-robin pick: first requester at or above rr_ptr, else wrap to the lowest requester.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_req[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = PTR_W'(i);
                end
                if (!hi_found && (PTR_W'(i) >= rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(i);
                end
            end
        end
        any_req       = |m_req;
        winner        = hi_found ? hi_idx : lo_idx;
        ptr_after_win = (winner == PTR_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
    end

    // Slave ID of the winner and request level of the current owner.
    always_comb begin
        win_slave_id = '0;
        owner_req    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (PTR_W'(i) == winner) begin
                win_slave_id = m_slave_id[i*SLAVE_ID_W +: SLAVE_ID_W];
            end
            if (PTR_W'(i) == owner) begin
                owner_req = m_req[i];
            end
        end
        at_limit    = (count == CNT_W'(TIMEOUT_CYCLES - 1));
        release_now = txn_done || !owner_req || at_limit;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: arbitrate in IDLE, hold in GRANT until release, single TURN cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = any_req ? ST_GRANT : ST_IDLE;
            ST_GRANT: state_next = release_now ? ST_TURN : ST_GRANT;
            ST_TURN:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Bus is occupied from the grant through the turnaround cycle.
    always_comb begin
        bus_busy = (state != ST_IDLE);
    end

    // Grant, slave select, pointer, timeout counter and timeout pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_grant         <= '0;
            slave_sel       <= '0;
            slave_sel_valid <= 1'b0;
            timeout         <= 1'b0;
            rr_ptr          <= '0;
            owner           <= '0;
            count           <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        m_grant         <= NUM_MASTERS'(1) << winner;
                        slave_sel       <= win_slave_id;
                        slave_sel_valid <= 1'b1;
                        rr_ptr          <= ptr_after_win;
                        owner           <= winner;
                        count           <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        m_grant         <= '0;
                        slave_sel_valid <= 1'b0;
                        // A completion on the last allowed cycle is a normal release.
                        timeout         <= at_limit && !txn_done;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
